// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle-handshake bus crossing: FSM encoding,
// default synchronizer depth and a helper for sizing the timeout counter.
package cdc_pkg;

  // Source-side transfer state.
  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  // Default depth of the synchronizer on the returning acknowledge.
  localparam int DEFAULT_SYNC_REGS = 5;

  // Counter width able to hold 0..cycles; a timeout of 0 still needs one bit.
  function automatic int tmo_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/cdc_bus_tx_if.sv
// Bus between the source port, the crossing block and the far domain.
//
// Handshake: a word moves from source to block on a rising clk edge where
// s_valid && s_ready. s_ready never depends on s_valid in the same cycle, and
// the source may hold s_valid high for back-to-back words. Toward the far
// domain the request is two-phase: every change of req_toggle announces a new
// xfer_data word, and the far side answers by making ack_toggle_async equal
// to req_toggle.
interface cdc_bus_tx_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  req_toggle;
  logic [DATA_WIDTH-1:0] xfer_data;
  logic                  ack_toggle_async;

  // Environment view: source and far-domain acknowledge.
  modport master (
    output s_valid,
    output s_data,
    output ack_toggle_async,
    input  s_ready,
    input  req_toggle,
    input  xfer_data
  );

  // Crossing block view.
  modport slave (
    input  s_valid,
    input  s_data,
    input  ack_toggle_async,
    output s_ready,
    output req_toggle,
    output xfer_data
  );

endinterface

// File: rtl/sync_block.sv
// Multi-flop synchronizer for a single level crossing into clk.
// No reset: the flops power up at 0, and resetting them would only add a
// second asynchronous path into the chain. Depth must be at least 2.
module sync_block #(
  parameter int C_NUM_SYNC_REGS = 5
) (
  input  logic clk,
  input  logic d_async,
  output logic q_sync
);

  logic [C_NUM_SYNC_REGS-1:0] sync_q = '0;

  // Shift the asynchronous level through the chain, one stage per edge.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[C_NUM_SYNC_REGS-2:0], d_async};
  end

  assign q_sync = sync_q[C_NUM_SYNC_REGS-1];

endmodule

// File: rtl/cdc_bus_tx.sv
// Source half of a two-phase bus crossing. A word is accepted in IDLE,
// parked on xfer_data and announced by flipping req_toggle; the block then
// waits until the resynchronised acknowledge level equals the request level.
// A watchdog flags an overdue acknowledge but never abandons the transfer,
// since dropping it would leave request and acknowledge polarities out of step.
module cdc_bus_tx
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int C_NUM_SYNC_REGS = DEFAULT_SYNC_REGS,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  cdc_bus_tx_if.slave  bus,
  output logic         busy,
  output logic         timeout_err,
  input  logic         err_clr,
  output logic [15:0]  xfer_count,
  output state_t       state_dbg
);

  localparam int             TW      = tmo_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam bit             TMO_EN  = (TIMEOUT_CYCLES != 0);

  state_t                state;
  logic                  req_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  s_ready_q;
  logic                  busy_q;
  logic [TW-1:0]         tmo_cnt;
  logic [TW-1:0]         tmo_cnt_next;
  logic                  tmo_hit;
  logic                  err_q;
  logic [15:0]           count_q;
  logic                  ack_sync;

  sync_block #(
    .C_NUM_SYNC_REGS (C_NUM_SYNC_REGS)
  ) u_ack_sync (
    .clk     (clk),
    .d_async (bus.ack_toggle_async),
    .q_sync  (ack_sync)
  );

  // Saturating wait counter; the error fires only on the edge that reaches
  // the limit, so a clear while still waiting is not immediately undone.
  always_comb begin
    tmo_cnt_next = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + TW'(1);
    tmo_hit      = TMO_EN && (state == WAIT_ACK) &&
                   (tmo_cnt != TMO_MAX) && (tmo_cnt_next == TMO_MAX);
  end

  // Transfer FSM: accept in IDLE, hold the word and wait for a level match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_q     <= 1'b0;
      data_q    <= '0;
      s_ready_q <= 1'b1;
      busy_q    <= 1'b0;
      tmo_cnt   <= '0;
      count_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.s_valid) begin
            data_q    <= bus.s_data;
            req_q     <= ~req_q;
            tmo_cnt   <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b1;
            state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          tmo_cnt <= tmo_cnt_next;
          if (ack_sync == req_q) begin
            count_q   <= count_q + 16'd1;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

  // Sticky overdue flag; a set on the same edge as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (tmo_hit) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.req_toggle = req_q;
  assign bus.xfer_data  = data_q;
  assign busy           = busy_q;
  assign timeout_err    = err_q;
  assign xfer_count     = count_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_cdc_bus_tx.sv
// Directed bench for cdc_bus_tx: reset, single and back-to-back transfers,
// watchdog behaviour, spurious acknowledges, counter wrap and reset while
// a transfer is outstanding.
module tb_cdc_bus_tx;
  import cdc_pkg::*;

  localparam int DW  = 32;
  localparam int NS  = 5;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         err_clr = 1'b0;
  logic         busy;
  logic         timeout_err;
  logic [15:0]  xfer_count;
  state_t       state_dbg;

  // Far-domain model: either echoes the request level at once or holds a
  // level set by the test.
  logic         ack_echo = 1'b0;
  logic         ack_lvl  = 1'b0;

  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;

  logic [DW-1:0] exp_q[$];

  cdc_bus_tx_if #(.DATA_WIDTH(DW)) bus();

  assign bus.ack_toggle_async = ack_echo ? bus.req_toggle : ack_lvl;

  cdc_bus_tx #(
    .DATA_WIDTH      (DW),
    .C_NUM_SYNC_REGS (NS),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr),
    .xfer_count  (xfer_count),
    .state_dbg   (state_dbg)
  );

  // Clock and free-running cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    ack_echo    = 1'b0;
    ack_lvl     = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    err_clr     = 1'b0;
    repeat (NS + 3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until s_ready is seen high (capped at 200).
  task automatic wait_ready(output int n);
    n = 0;
    while (bus.s_ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Presents one word, and returns edges from accept to s_ready high again.
  task automatic run_xfer(input logic [DW-1:0] data, output int lat);
    int n;
    wait_ready(n);
    bus.s_valid = 1'b1;
    bus.s_data  = data;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    wait_ready(lat);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int lat;
    do_reset();
    ack_echo = 1'b1;
    run_xfer(32'h1234_5678, lat);
    total++; if (xfer_count !== 16'd1) begin bad++; $display("FAIL reset_pre_count: got %0h expected 1", xfer_count); end
    // Start a second transfer and leave it outstanding.
    ack_echo = 1'b0;
    ack_lvl  = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hCAFE_0002;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_pre_busy: got %0b expected 1", busy); end
    @(negedge clk);
    rst_n   = 1'b0;
    ack_lvl = 1'b0;
    #1;
    total++; if (bus.req_toggle !== 1'b0) begin bad++; $display("FAIL reset_req: got %0b expected 0", bus.req_toggle); end
    total++; if (bus.xfer_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %0h expected 0", bus.xfer_data); end
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b expected 1", bus.s_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b expected 0", timeout_err); end
    total++; if (xfer_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0h expected 0", xfer_count); end
    total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    repeat (NS + 3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %0b expected 1", bus.s_ready); end
  endtask

  task automatic test_single();
    int n;
    int t_acc;
    do_reset();
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hA5A5_0001;
    @(posedge clk);
    #1;
    t_acc       = cyc;
    bus.s_valid = 1'b0;
    bus.s_data  = 32'hDEAD_BEEF;
    total++; if (bus.req_toggle !== 1'b1) begin bad++; $display("FAIL single_req: got %0b expected 1", bus.req_toggle); end
    total++; if (bus.xfer_data !== 32'hA5A5_0001) begin bad++; $display("FAIL single_data: got %0h expected a5a50001", bus.xfer_data); end
    total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL single_ready_low: got %0b expected 0", bus.s_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %0b expected 1", busy); end
    repeat (3) @(posedge clk);
    #1;
    ack_lvl = 1'b1;
    n = 0;
    while (bus.s_ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      total++; if (bus.xfer_data !== 32'hA5A5_0001) begin bad++; $display("FAIL single_hold_data: got %0h expected a5a50001", bus.xfer_data); end
      total++; if (bus.req_toggle !== 1'b1) begin bad++; $display("FAIL single_hold_req: got %0b expected 1", bus.req_toggle); end
    end
    total++; if (cyc - t_acc !== 9) begin bad++; $display("FAIL single_latency: got %0d expected 9", cyc - t_acc); end
    total++; if (xfer_count !== 16'd1) begin bad++; $display("FAIL single_count: got %0h expected 1", xfer_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %0b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int n;
    int t_prev;
    logic [DW-1:0] exp;
    logic exp_req;
    do_reset();
    ack_echo = 1'b1;
    t_prev   = 0;
    for (int i = 1; i <= 4; i++) exp_q.push_back(DW'(i));
    bus.s_valid = 1'b1;
    bus.s_data  = exp_q[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      exp     = exp_q.pop_front();
      exp_req = ~i[0];
      total++; if (bus.xfer_data !== exp) begin bad++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, bus.xfer_data, exp); end
      total++; if (bus.req_toggle !== exp_req) begin bad++; $display("FAIL b2b_req[%0d]: got %0b expected %0b", i, bus.req_toggle, exp_req); end
      if (i > 0) begin
        total++; if (cyc - t_prev !== 7) begin bad++; $display("FAIL b2b_spacing[%0d]: got %0d expected 7", i, cyc - t_prev); end
      end
      t_prev = cyc;
      if (exp_q.size() > 0) bus.s_data = exp_q[0];
      else bus.s_valid = 1'b0;
      wait_ready(n);
      total++; if (n !== 6) begin bad++; $display("FAIL b2b_ready[%0d]: got %0d expected 6", i, n); end
    end
    total++; if (xfer_count !== 16'd4) begin bad++; $display("FAIL b2b_count: got %0h expected 4", xfer_count); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h0000_0077;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_early: got %0b expected 0", timeout_err); end
    @(posedge clk);
    #1;
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_rise: got %0b expected 1", timeout_err); end
    repeat (5) @(posedge clk);
    #1;
    total++; if (state_dbg !== WAIT_ACK) begin bad++; $display("FAIL tmo_still_wait: got %0d expected 1", state_dbg); end
    total++; if (bus.req_toggle !== 1'b1) begin bad++; $display("FAIL tmo_req: got %0b expected 1", bus.req_toggle); end
    ack_lvl = 1'b1;
    wait_ready(n);
    total++; if (n !== 6) begin bad++; $display("FAIL tmo_complete: got %0d expected 6", n); end
    total++; if (xfer_count !== 16'd1) begin bad++; $display("FAIL tmo_count: got %0h expected 1", xfer_count); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky: got %0b expected 1", timeout_err); end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_clear: got %0b expected 0", timeout_err); end
    // Second overdue transfer with the clear landing on the setting edge.
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h0000_0088;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_early2: got %0b expected 0", timeout_err); end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_set_wins: got %0b expected 1", timeout_err); end
    ack_lvl = 1'b0;
    wait_ready(n);
    total++; if (xfer_count !== 16'd2) begin bad++; $display("FAIL tmo_count2: got %0h expected 2", xfer_count); end
  endtask

  task automatic test_spurious_and_wrap();
    int lat;
    do_reset();
    ack_lvl = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++; if (xfer_count !== 16'd0) begin bad++; $display("FAIL spur_count1: got %0h expected 0", xfer_count); end
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL spur_ready1: got %0b expected 1", bus.s_ready); end
    ack_lvl = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if (xfer_count !== 16'd0) begin bad++; $display("FAIL spur_count2: got %0h expected 0", xfer_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL spur_busy: got %0b expected 0", busy); end
    ack_echo = 1'b1;
    run_xfer(32'h5555_AAAA, lat);
    total++; if (lat !== 6) begin bad++; $display("FAIL spur_next_latency: got %0d expected 6", lat); end
    total++; if (xfer_count !== 16'd1) begin bad++; $display("FAIL spur_next_count: got %0h expected 1", xfer_count); end
    total++; if (bus.xfer_data !== 32'h5555_AAAA) begin bad++; $display("FAIL spur_next_data: got %0h expected 5555aaaa", bus.xfer_data); end
    // Preload the completion counter to its top value.
    force dut.count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.count_q;
    @(posedge clk);
    #1;
    total++; if (xfer_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload: got %0h expected ffff", xfer_count); end
    run_xfer(32'h0000_0BAD, lat);
    total++; if (xfer_count !== 16'h0000) begin bad++; $display("FAIL wrap_count: got %0h expected 0", xfer_count); end
    total++; if (lat !== 6) begin bad++; $display("FAIL wrap_latency: got %0d expected 6", lat); end
  endtask

  task automatic test_reset_wait();
    int lat;
    do_reset();
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hC0DE_0003;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rw_busy: got %0b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.req_toggle !== 1'b0) begin bad++; $display("FAIL rw_req: got %0b expected 0", bus.req_toggle); end
    total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL rw_state: got %0d expected 0", state_dbg); end
    total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL rw_ready: got %0b expected 1", bus.s_ready); end
    ack_lvl = 1'b0;
    repeat (NS + 3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ack_echo = 1'b1;
    run_xfer(32'hC0DE_0004, lat);
    total++; if (lat !== 6) begin bad++; $display("FAIL rw_latency: got %0d expected 6", lat); end
    total++; if (xfer_count !== 16'd1) begin bad++; $display("FAIL rw_count: got %0h expected 1", xfer_count); end
    total++; if (bus.req_toggle !== 1'b1) begin bad++; $display("FAIL rw_req_after: got %0b expected 1", bus.req_toggle); end
    total++; if (bus.xfer_data !== 32'hC0DE_0004) begin bad++; $display("FAIL rw_data: got %0h expected c0de0004", bus.xfer_data); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    do_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_spurious_and_wrap();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
